rr_arbiter: RTL

//   Parametrised N-way Moore arbiter with registered one-hot grant, hold-until-release

---
 rtl/rr_arbiter_if.sv | 36 +++
 rtl/rr_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_if.sv
// Bundle between the N requesters and the arbiter.
//
// Handshake: a requester raises req[i] and keeps it high for as long as it
// needs the resource; it owns the resource on every cycle where grant[i] is
// high, and it gives the resource back by lowering req[i]. The arbiter changes
// grant only on a clock edge. en gates whether new grants may be issued.
interface rr_arbiter_if #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
);
    localparam int IDW = $clog2(N_REQ);
    localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_id;
    logic             busy;
    logic             preempt;

    // Observability of the arbiter's internal state for checkers.
    logic             dbg_state;    // 0 = IDLE, 1 = GRANT
    logic [HCW-1:0]   dbg_hold_cnt;

    // Requester side drives requests and the enable.
    modport master (
        output en, req,
        input  grant, grant_id, busy, preempt, dbg_state, dbg_hold_cnt
    );

    // Arbiter side.
    modport slave (
        input  en, req,
        output grant, grant_id, busy, preempt, dbg_state, dbg_hold_cnt
    );
endinterface

// File: rtl/rr_arbiter.sv
// N-way Moore arbiter with a registered one-hot grant, hold-until-release
// ownership, round-robin (MODE 0) or fixed-priority (MODE 1) selection, and a
// hold limit that forces rotation while other requesters are waiting.
// Every output comes straight from a register; there is no path from req to
// grant inside a single cycle.
module rr_arbiter #(
    parameter int N_REQ    = 4,   // 2..16
    parameter int MAX_HOLD = 8,   // 0 = unlimited hold
    parameter int MODE     = 0    // 0 = round-robin, 1 = fixed priority (index 0 highest)
) (
    input  logic          clk,
    input  logic          reset_n,
    rr_arbiter_if.slave   bus
);
    localparam int IDW      = $clog2(N_REQ);
    localparam int HCW      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int HOLD_LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    localparam logic [HCW-1:0] HOLD_LIM_V = HCW'(HOLD_LIM);
    localparam logic [IDW-1:0] LAST_RST   = IDW'(N_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e           state_q,   state_d;
    logic [N_REQ-1:0] grant_q,   grant_d;
    logic [IDW-1:0]   id_q,      id_d;
    logic [IDW-1:0]   last_q,    last_d;
    logic [HCW-1:0]   hold_q,    hold_d;
    logic             preempt_q, preempt_d;

    logic             owner_req;
    logic [N_REQ-1:0] other;
    logic [IDW:0]     pick_all;     // {found, index}
    logic [IDW:0]     pick_other;   // {found, index}

    // Selection among the candidate bits. Both loops run from the least to
    // the most preferred candidate so the last hit is the winner, which keeps
    // the function free of early exits.
    function automatic logic [IDW:0] pick(input logic [N_REQ-1:0] cand,
                                          input logic [IDW-1:0]   ptr);
        logic           found;
        logic [IDW-1:0] sel;
        logic [IDW-1:0] idx;
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        if (MODE == 1) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    found = 1'b1;
                    sel   = IDW'(i);
                end
            end
        end else begin
            // Search last+1, last+2, ... ; the pointer itself is tried last.
            for (int k = N_REQ; k >= 1; k--) begin
                idx = IDW'((int'(ptr) + k) % N_REQ);
                if (cand[idx]) begin
                    found = 1'b1;
                    sel   = idx;
                end
            end
        end
        return {found, sel};
    endfunction

    // Request of the current owner and the set of competing requesters.
    always_comb begin
        owner_req  = bus.req[id_q] & (state_q == GRANT);
        other      = (state_q == GRANT) ? (bus.req & ~grant_q) : bus.req;
        pick_all   = pick(bus.req, last_q);
        pick_other = pick(other, last_q);
    end

    // Next-state and next-output decode for the IDLE/GRANT machine.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        id_d      = id_q;
        last_d    = last_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                hold_d = '0;
                if (bus.en && pick_all[IDW]) begin
                    state_d = GRANT;
                    grant_d = N_REQ'(1) << pick_all[IDW-1:0];
                    id_d    = pick_all[IDW-1:0];
                    last_d  = pick_all[IDW-1:0];
                end
            end

            GRANT: begin
                if (!owner_req) begin
                    // Release: hand over with no idle cycle when allowed.
                    hold_d = '0;
                    if (bus.en && pick_other[IDW]) begin
                        grant_d = N_REQ'(1) << pick_other[IDW-1:0];
                        id_d    = pick_other[IDW-1:0];
                        last_d  = pick_other[IDW-1:0];
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        id_d    = '0;
                    end
                end else if ((MAX_HOLD != 0) && bus.en && pick_other[IDW] &&
                             (hold_q == HOLD_LIM_V)) begin
                    // Hold limit reached under contention: rotate ownership.
                    hold_d    = '0;
                    preempt_d = 1'b1;
                    grant_d   = N_REQ'(1) << pick_other[IDW-1:0];
                    id_d      = pick_other[IDW-1:0];
                    last_d    = pick_other[IDW-1:0];
                end else if ((MAX_HOLD != 0) && pick_other[IDW] &&
                             (hold_q < HOLD_LIM_V)) begin
                    // Keep the owner; count only cycles where someone waits.
                    hold_d = hold_q + HCW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                id_d    = '0;
                hold_d  = '0;
            end
        endcase
    end

    // State and output registers; reset clears the grant immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            last_q    <= LAST_RST;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    // Outputs are direct register decodes.
    assign bus.grant        = grant_q;
    assign bus.grant_id     = id_q;
    assign bus.busy         = (state_q == GRANT);
    assign bus.preempt      = preempt_q;
    assign bus.dbg_state    = state_q;
    assign bus.dbg_hold_cnt = hold_q;

    // Structural invariants of the registered outputs.
    a_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(grant_q));
    a_grant_id: assert property (@(posedge clk) disable iff (!reset_n)
        ((grant_q == '0) && (id_q == '0)) || (grant_q == (N_REQ'(1) << id_q)));
    a_busy: assert property (@(posedge clk) disable iff (!reset_n)
        ((state_q == GRANT) == (|grant_q)));
    a_preempt_busy: assert property (@(posedge clk) disable iff (!reset_n)
        (preempt_q |-> (|grant_q)));
    a_hold_range: assert property (@(posedge clk) disable iff (!reset_n)
        (hold_q <= HOLD_LIM_V));

endmodule
